led_shift_engine: RTL and testbench
===================================

# led_shift_engine

Parametrised serial/parallel LED shift engine for the Tang Nano 9K board designs. It divides the board clock into a programmable step tick. On each tick it shifts, rotates or holds an internal register, taking serial input from a synchronised active-low push-button. The register drives an active-low LED bank and a serial-out pin for chaining, and it can be parallel-loaded at any time.

## Interface
- WIDTH, 6, register and LED width; legal range 2..32
- TICK_CYCLES, 27000000, clock cycles per step tick (1 s at 27 MHz); minimum 2
- ACTIVE_LOW_OUT, 1, 1: led = ~q; 0: led = q

- clk  in  1  board clock (27 MHz)
- reset  in  1  synchronous, active-low; sampled only on rising clk
- data  in  1  serial input, active low (button); asynchronous to clk
- mode  in  2  00 shift left, 01 shift right, 10 rotate left, 11 hold
- load_n  in  1  active-low parallel-load request, synchronous to clk
- load_val  in  WIDTH  parallel load value, active-high logical bits
- led  out  WIDTH  LED drive, polarity per ACTIVE_LOW_OUT
- sout  out  1  registered copy of the last bit shifted or rotated out
- tick  out  1  one-cycle pulse, high in the cycle the step is taken

## Operation
- Internal logical register q[WIDTH-1:0]. A 1 means the LED is lit.
- data passes through a 2-flop synchroniser, then is inverted: din = ~data_sync2. A pressed button gives din = 1.
- Step actions, taken on a cycle where tick = 1 and load_n = 1:
  - shift left: q <= {q[WIDTH-2:0], din}; sout <= q[WIDTH-1]
  - shift right: q <= {din, q[WIDTH-1:1]}; sout <= q[0]
  - rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}; sout <= q[WIDTH-1]; din ignored
  - hold: q and sout unchanged
- mode is sampled only in the tick cycle. Mode changes between ticks have no effect.
- Parallel load, when load_n = 0 in a cycle:
  - q <= load_val; sout unchanged.
  - Tick counter restarts at 0.
  - Load has priority over a coincident tick. That tick's step is discarded and tick still pulses.
  - load_n held low keeps reloading, and no step occurs.
- Reset, synchronous, highest priority:
  - q = 0, which gives led = all 1s when ACTIVE_LOW_OUT = 1.
  - sout = 0, tick = 0, counter = 0.
  - Synchroniser flops are set to 1 (button released).
- Reset mid-run: all state returns to reset values at the next edge. No partial step completes.

## Timing
- Counter runs 0..TICK_CYCLES-1 and wraps to 0. tick = 1 exactly when counter == TICK_CYCLES-1.
- Period is exactly TICK_CYCLES cycles, with no +1 slip.
- After reset or load is released, the first tick is asserted TICK_CYCLES cycles later: edge counts 0..TICK_CYCLES-1, tick high in the last.
- q, led and sout update on the edge ending the tick cycle. Visible latency from tick to led is 1 cycle.
- led is combinational from q only: no extra register, no glitch path from inputs.
- Latency from data to din is 2 cycles. A data change needs at least 3 cycles of setup before the tick cycle to be captured.
- Load latency: led reflects load_val 1 cycle after load_n is sampled low.

## Structure
- Package led_shift_pkg holds:
  - mode constants MODE_SHL = 2'b00, MODE_SHR = 2'b01, MODE_ROL = 2'b10, MODE_HOLD = 2'b11
  - function cnt_w(TICK_CYCLES) = $clog2(TICK_CYCLES)
- Sub-module tick_gen (parameter TICK_CYCLES):
  - Ports clk, reset, restart, tick.
  - Owns the counter; restart is driven by ~load_n.
- Top module holds the synchroniser, q, sout and output polarity logic.

## Test plan
Bench parameters: WIDTH = 6, TICK_CYCLES = 4, ACTIVE_LOW_OUT = 1.

1. Reset and tick phase: reset low 3 cycles with data = 1 -> led = 6'b111111, sout = 0, tick = 0. After release, tick first high in the 4th cycle, then every 4 cycles.
2. Shift left fill: mode = 00, data = 0 held -> after ticks 1..6, q = 000001, 000011, …, 111111; led after tick 6 = 000000; sout stays 0.
3. Rotate: load_val = 6'b000001, load_n low 1 cycle, then mode = 10 -> q = 000010, 000100, …, 100000, 000001 after 6 ticks; sout = 1 after the tick that wraps bit 5.
4. Shift right with button release: q = 6'b101010, mode = 01, data = 1 -> q = 010101, then 001010; sout = 0, then 1.
5. Load vs tick collision: load_n low exactly in a tick cycle with load_val = 6'b110011 -> q = 110011 with no step applied. Next tick comes 4 cycles after load_n rises.
6. Hold and mid-run reset: mode = 11 across 3 ticks -> q unchanged. Reset asserted 1 cycle after a tick -> next edge gives q = 0, led = 111111, and the counter restarts.

Source files
------------

// File: rtl/led_shift_pkg.sv
// Shared constants and helpers for the LED shift engine.
// Mode encodings and the tick counter width function.
package led_shift_pkg;

  localparam logic [1:0] MODE_SHL  = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_ROL  = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  // Bits needed to count 0..tick_cycles-1.
  function automatic int cnt_w(input int tick_cycles);
    return $clog2(tick_cycles);
  endfunction

endpackage

// File: rtl/led_shift_engine_tick_gen.sv
// Step tick generator: free-running 0..TICK_CYCLES-1 counter with restart.
// tick is decoded from the counter, so it is high for exactly one cycle per period.
module tick_gen
  import led_shift_pkg::*;
#(
  parameter int TICK_CYCLES = 27000000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = cnt_w(TICK_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] count;

  if (TICK_CYCLES < 2) begin : g_bad_tick
    $error("tick_gen: TICK_CYCLES must be at least 2");
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (restart || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/led_shift_engine.sv
// LED shift engine: synchronised button input, shift/rotate/hold register,
// parallel load and polarity-selectable LED drive.
module led_shift_engine
  import led_shift_pkg::*;
#(
  parameter int WIDTH          = 6,
  parameter int TICK_CYCLES    = 27000000,
  parameter bit ACTIVE_LOW_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data,
  input  logic [1:0]       mode,
  input  logic             load_n,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] led,
  output logic             sout,
  output logic             tick
);

  logic             data_sync1;
  logic             data_sync2;
  logic             din;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  logic             sout_next;

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("led_shift_engine: WIDTH must be in 2..32");
  end

  tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .restart(~load_n),
    .tick   (tick)
  );

  // Synchroniser idles at 1 so a released button reads as din = 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_sync1 <= 1'b1;
      data_sync2 <= 1'b1;
    end else begin
      data_sync1 <= data;
      data_sync2 <= data_sync1;
    end
  end

  assign din = ~data_sync2;

  // Load wins over a coincident tick; that step is simply dropped.
  always_comb begin
    q_next    = q;
    sout_next = sout;
    if (!load_n) begin
      q_next = load_val;
    end else if (tick) begin
      case (mode)
        MODE_SHL: begin
          q_next    = {q[WIDTH-2:0], din};
          sout_next = q[WIDTH-1];
        end
        MODE_SHR: begin
          q_next    = {din, q[WIDTH-1:1]};
          sout_next = q[0];
        end
        MODE_ROL: begin
          q_next    = {q[WIDTH-2:0], q[WIDTH-1]};
          sout_next = q[WIDTH-1];
        end
        default: begin
          q_next    = q;
          sout_next = sout;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q    <= '0;
      sout <= 1'b0;
    end else begin
      q    <= q_next;
      sout <= sout_next;
    end
  end

  assign led = ACTIVE_LOW_OUT ? ~q : q;

endmodule

// File: tb/tb_led_shift_engine.sv
// Scoreboard bench for led_shift_engine (WIDTH=6, TICK_CYCLES=4, active-low LEDs).
module tb_led_shift_engine;

  logic       clk;
  logic       reset;
  logic       data;
  logic [1:0] mode;
  logic       load_n;
  logic [5:0] load_val;
  logic [5:0] led;
  logic       sout;
  logic       tick;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [5:0] q;
    logic       s;
  } exp_t;

  exp_t sb[$];

  led_shift_engine #(
    .WIDTH(6),
    .TICK_CYCLES(4),
    .ACTIVE_LOW_OUT(1'b1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .data    (data),
    .mode    (mode),
    .load_n  (load_n),
    .load_val(load_val),
    .led     (led),
    .sout    (sout),
    .tick    (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [5:0] q, input logic s);
    exp_t e;
    e.q = q;
    e.s = s;
    sb.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  // Consume n ticks; returns one cycle after the last tick so its step is applied.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bit found = 1'b0;
      for (int b = 0; b < 20 && !found; b++) begin
        if (tick === 1'b1) found = 1'b1;
        next_cycle();
      end
      if (!found) begin
        checks++;
        fails++;
        $display("FAIL tick_timeout: no tick seen for tick %0d of %0d", i + 1, n);
      end
    end
  endtask

  // Returns while still inside the tick cycle.
  task automatic wait_tick_cycle();
    bit found = 1'b0;
    for (int b = 0; b < 20; b++) begin
      if (tick === 1'b1) begin
        found = 1'b1;
        break;
      end
      next_cycle();
    end
    if (!found) begin
      checks++;
      fails++;
      $display("FAIL tick_cycle_timeout: no tick seen");
    end
  endtask

  // Monitor: tick phase every cycle, scoreboard pop on the cycle after each tick.
  initial begin
    bit  pend = 1'b0;
    int  since = 0;
    exp_t e;
    logic [5:0] exp_led;
    forever begin
      @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL sb_unexpected_tick: led=%b sout=%b with no expected entry", led, sout);
        end else begin
          e = sb.pop_front();
          exp_led = ~e.q;
          check("step_led", {26'd0, led}, {26'd0, exp_led});
          check("step_sout", {31'd0, sout}, {31'd0, e.s});
        end
      end
      if (reset === 1'b1 && tick === 1'b1) pend = 1'b1;
      if (reset !== 1'b1 || load_n === 1'b0) begin
        since = 0;
      end else begin
        since++;
        check("tick_phase", {31'd0, tick}, {31'd0, (since % 4 == 0)});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    data     = 1'b1;
    mode     = 2'b00;
    load_n   = 1'b1;
    load_val = 6'd0;

    // Reset state
    repeat (3) next_cycle();
    check("rst_led", {26'd0, led}, 32'h3f);
    check("rst_sout", {31'd0, sout}, 32'd0);
    check("rst_tick", {31'd0, tick}, 32'd0);

    // Shift left fill with button pressed
    push_exp(6'b000001, 1'b0);
    push_exp(6'b000011, 1'b0);
    push_exp(6'b000111, 1'b0);
    push_exp(6'b001111, 1'b0);
    push_exp(6'b011111, 1'b0);
    push_exp(6'b111111, 1'b0);
    reset = 1'b1;
    data  = 1'b0;
    mode  = 2'b00;
    wait_ticks(6);

    // Rotate a single bit all the way around
    load_val = 6'b000001;
    load_n   = 1'b0;
    mode     = 2'b10;
    next_cycle();
    load_n = 1'b1;
    check("load_led", {26'd0, led}, 32'h3e);
    push_exp(6'b000010, 1'b0);
    push_exp(6'b000100, 1'b0);
    push_exp(6'b001000, 1'b0);
    push_exp(6'b010000, 1'b0);
    push_exp(6'b100000, 1'b0);
    push_exp(6'b000001, 1'b1);
    wait_ticks(6);

    // Shift right with button released
    load_val = 6'b101010;
    load_n   = 1'b0;
    mode     = 2'b01;
    data     = 1'b1;
    next_cycle();
    load_n = 1'b1;
    push_exp(6'b010101, 1'b0);
    push_exp(6'b001010, 1'b1);
    wait_ticks(2);

    // Load coinciding with a tick: no step, sout kept
    push_exp(6'b110011, 1'b1);
    wait_tick_cycle();
    load_val = 6'b110011;
    load_n   = 1'b0;
    next_cycle();
    load_n = 1'b1;
    mode   = 2'b11;

    // Hold across three ticks
    push_exp(6'b110011, 1'b1);
    push_exp(6'b110011, 1'b1);
    push_exp(6'b110011, 1'b1);
    wait_ticks(3);

    // Reset one cycle after a tick
    reset = 1'b0;
    next_cycle();
    check("midrst_led", {26'd0, led}, 32'h3f);
    check("midrst_sout", {31'd0, sout}, 32'd0);
    check("midrst_tick", {31'd0, tick}, 32'd0);
    push_exp(6'b000000, 1'b0);
    push_exp(6'b000000, 1'b0);
    reset = 1'b1;
    wait_ticks(2);

    repeat (3) next_cycle();
    check("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
